// File: rtl/sdspi_pkg.sv
// Shared definitions for the SD clock path.
//   sdck_state_t  : sequencing states of sdckctrl
//   LGMAXDIV      : width of the SD clock divider field (matches sdckgen)
//   SDCK_INIT_SPD : divider applied out of reset (100 kHz from 100 MHz)
package sdspi_pkg;

    localparam int LGMAXDIV = 8;
    localparam logic [LGMAXDIV-1:0] SDCK_INIT_SPD = 8'd252;

    typedef enum logic [2:0] {
        IDLE,
        QUIET,
        STOP,
        LOAD,
        RUN,
        POST,
        DONE
    } sdck_state_t;

endpackage

// File: rtl/sdckctrl.sv
// sdckctrl: sequences SD clock divider/phase/shutdown changes into sdckgen so
// that each change lands glitch-free while the bus is quiet, then waits for a
// minimum run of SD clock edges before acknowledging.
//
// Optional feature macro: SDCKCTRL_AUTOSTOP_EN
//   defined   : while IDLE, i_stall forces o_cfg_shutdown high (one-cycle latency)
//   undefined : i_stall is ignored
//
// Ports:
//   i_clk, i_reset          system clock, async active-high reset
//   i_req, i_req_*          change request (level) and requested config
//   o_ack, o_busy           one-cycle done pulse, sequence in progress
//   i_cmd_busy, i_dat_busy  bus engines mid-transfer
//   i_stall                 receive buffer full
//   i_ckstb, i_hlfck        SD clock strobes from sdckgen
//   i_ckspd                 divider currently applied by sdckgen
//   o_cfg_*                 configuration driven into sdckgen
//
// state | meaning
// IDLE  | holding current config, waiting for i_req
// QUIET | request latched, waiting for cmd/dat engines to go idle
// STOP  | clock shut down, waiting for the clock to actually stop
// LOAD  | new divider/phase presented with clock still stopped
// RUN   | clock restarted (or left off), waiting for divider to take effect
// POST  | counting SD clock edges after the change
// DONE  | o_ack pulse
module sdckctrl
    import sdspi_pkg::*;
#(
    parameter int LGMAXDIV = sdspi_pkg::LGMAXDIV,
    parameter int NPOST    = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req,
    input  logic [LGMAXDIV-1:0] i_req_ckspd,
    input  logic                i_req_clk90,
    input  logic                i_req_shutdown,
    output logic                o_ack,
    output logic                o_busy,
    input  logic                i_cmd_busy,
    input  logic                i_dat_busy,
    input  logic                i_stall,
    input  logic                i_ckstb,
    input  logic                i_hlfck,
    input  logic [LGMAXDIV-1:0] i_ckspd,
    output logic [LGMAXDIV-1:0] o_cfg_ckspd,
    output logic                o_cfg_clk90,
    output logic                o_cfg_shutdown
);

    localparam int CW = $clog2(NPOST + 1);

    sdck_state_t         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [LGMAXDIV-1:0] req_spd_q, cfg_spd_q;
    logic                req_clk90_q, req_shut_q;
    logic                cfg_clk90_q, cfg_shut_q, cur_shut_q;
    logic                ack_q, busy_q, stop_armed_q;
    logic                idle_shut;
    logic                unused_inputs;

`ifdef SDCKCTRL_AUTOSTOP_EN
    assign idle_shut     = cur_shut_q | i_stall;
    assign unused_inputs = i_hlfck;
`else
    assign idle_shut     = cur_shut_q;
    assign unused_inputs = i_hlfck ^ i_stall;
`endif

    // Saturating edge counter: never wraps past NPOST.
    assign cnt_inc = (i_ckstb && (cnt_q != CW'(NPOST))) ? cnt_q + CW'(1) : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (i_req) state_d = QUIET;
            QUIET: if (!i_cmd_busy && !i_dat_busy) state_d = STOP;
            // A strobe in the first STOP cycle may predate the shutdown request.
            STOP:  if (stop_armed_q && i_ckstb) state_d = LOAD;
            LOAD:  state_d = RUN;
            RUN: begin
                if (req_shut_q) begin
                    state_d = DONE;
                end else if (i_ckspd == req_spd_q) begin
                    state_d = POST;
                    cnt_d   = '0;
                end
            end
            POST: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(NPOST)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_spd_q    <= LGMAXDIV'(SDCK_INIT_SPD);
            req_clk90_q  <= 1'b0;
            req_shut_q   <= 1'b1;
            cfg_spd_q    <= LGMAXDIV'(SDCK_INIT_SPD);
            cfg_clk90_q  <= 1'b0;
            cfg_shut_q   <= 1'b1;
            cur_shut_q   <= 1'b1;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            stop_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ack_q        <= (state_d == DONE);
            busy_q       <= (state_d != IDLE);
            stop_armed_q <= (state_q == STOP);

            if (state_q == IDLE && i_req) begin
                req_spd_q   <= i_req_ckspd;
                // sdckgen cannot run divider 0 without the 90-degree phase.
                req_clk90_q <= i_req_clk90 | (i_req_ckspd == '0);
                req_shut_q  <= i_req_shutdown;
            end

            if (state_q == IDLE && state_d == IDLE) cfg_shut_q <= idle_shut;
            if (state_q == QUIET && state_d == STOP) cfg_shut_q <= 1'b1;
            if (state_q == STOP && state_d == LOAD) begin
                cfg_spd_q   <= req_spd_q;
                cfg_clk90_q <= req_clk90_q;
            end
            if (state_q == LOAD) begin
                cfg_shut_q <= req_shut_q;
                cur_shut_q <= req_shut_q;
            end
        end
    end

    assign o_ack          = ack_q;
    assign o_busy         = busy_q;
    assign o_cfg_ckspd    = cfg_spd_q;
    assign o_cfg_clk90    = cfg_clk90_q;
    assign o_cfg_shutdown = cfg_shut_q;

endmodule
